mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Sequencer and two-way arbiter for the CPU's single-port memory bus. It shares the bus between the instruction-fetch path and the CU-driven load/store path. Each accepted request becomes one complete memory transaction with a variable-latency `mem_ready` handshake and a bounded-wait timeout. The block sits between the IR/PC fetch logic, the CU data path and the memory model.

## Interface
Parameters:
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width
- `TIMEOUT`, 16, max BUSY cycles without `mem_ready` before abort (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request, level, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle completion pulse, fetch
- `if_err`  out  1  valid with `if_ack`: transaction timed out
- `if_rdata`  out  DATA_W  fetched data, held until next fetch ack
- `ls_req`  in  1  load/store request, level, held until `ls_ack`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_ack`  out  1  one-cycle completion pulse, load/store
- `ls_err`  out  1  valid with `ls_ack`: transaction timed out
- `ls_rdata`  out  DATA_W  load data, held until next load ack
- `mem_en`  out  1  bus cycle active
- `mem_we`  out  1  write strobe, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completes current cycle
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, BUSY and ACK.
- **IDLE:**
  - If either request is high, the arbiter picks a winner and latches its addr, we and wdata into the `mem_*` registers.
  - The `grant` register records the winner, then the FSM goes to BUSY.
  - Fetch is always a read (`mem_we`=0).
- **Arbitration:** round-robin with one `last` bit.
  - A lone requester always wins.
  - On a tie, the port not granted last wins.
  - `last` updates only on a grant.
  - Reset value is `last`=LS, so fetch wins the first tie.
- **BUSY:**
  - `mem_en`=1. `mem_addr`, `mem_we` and `mem_wdata` stay stable for the whole transaction.
  - The wait counter clears on entry and increments each cycle that `mem_ready`=0.
  - `mem_ready`=1 → go to ACK. On a read, `mem_rdata` is captured into the granted port's rdata register.
  - If `mem_ready`=0 and counter = TIMEOUT−1 → go to ACK with err. The granted port's rdata is forced to 0 on a read; a store leaves rdata untouched.
  - If ready and the timeout coincide, ready wins and err=0.
- **ACK:**
  - `mem_en`=0.
  - The granted port's ack is 1 for exactly one cycle, with err valid. The other port's ack/err are 0.
  - Next state is always IDLE.
- Requests sampled in IDLE after ACK count as new transactions. A requester keeping req high issues back-to-back.
- Stores never modify `ls_rdata`.
- Requests during BUSY/ACK wait; they are not queued beyond the held level.
- `mem_ready` is ignored outside BUSY.
- Input changes while a port is waiting are legal only while that port is not granted. The latched copy is used once granted.

## Timing
- **Reset values:**
  - State IDLE; `last`=LS; counter 0.
  - All acks/errs 0; `mem_en`, `mem_we` 0; `mem_addr`, `mem_wdata` 0.
  - `if_rdata`, `ls_rdata` 0; `busy` 0.
- **Zero-wait memory** (ready in first BUSY cycle):
  - req seen in cycle 0.
  - `mem_en` in cycle 1.
  - ack in cycle 2.
  - IDLE in cycle 3.
  - req→ack latency is 2 cycles; peak throughput is one transaction per 3 cycles.
- **N wait cycles:** ack arrives in cycle 2+N.
- **Timeout:** BUSY lasts exactly TIMEOUT cycles, and the err ack appears in cycle TIMEOUT+1.
- **Registering:** all outputs are registered, with no combinational path from input to output.
- **Reset asserted mid-transaction:** immediate asynchronous return to reset values. `mem_en` drops, no ack is issued, and the transaction is lost, so the requester must re-request.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding localparams (IDLE/BUSY/ACK);
  - requester IDs (GNT_IF=0, GNT_LS=1);
  - default ADDR_W/DATA_W.
- Sub-module `arb_rr2` is purely combinational: inputs `if_req`, `ls_req`, `last`; outputs `gnt_valid`, `gnt_id`. The `last` register stays in the top level.
- Wait counter width is `$clog2(TIMEOUT)`.

## Test plan
- **Single fetch, zero-wait:** `if_addr`=8'h10, memory returns 8'hA5 with ready in cycle 1 → `if_ack` cycle 2, `if_rdata`=8'hA5, `if_err`=0, `busy` high cycles 1–2.
- **Store with 3 wait cycles:** `ls_we`=1, addr 8'h20, wdata 8'h3C → `mem_we`=1 and stable addr/data for 4 BUSY cycles, `ls_ack` in cycle 5, `ls_rdata` unchanged.
- **Simultaneous requests held high for 4 transactions:** grants alternate IF, LS, IF, LS starting with IF after reset; each ack occurs only on its own port.
- **Timeout:** `mem_ready` held 0 with TIMEOUT=16 → `ls_ack` with `ls_err`=1 in cycle 17, `ls_rdata`=0 on a load. Also ready arriving in the 16th BUSY cycle → ack without err.
- **Reset in the second BUSY cycle:** `mem_en`, `busy` and all acks go 0 immediately without a clock edge. After release, held requests restart with `last`=LS.
- **Back-to-back fetch with req never dropped:** two distinct transactions, acks 3 cycles apart, no extra transaction between them.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory-bus sequencer and its arbiter.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request, completion and memory-bus signals of the two-way bus sequencer.
interface mem_bus_arbiter_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic              ls_err;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    // Arbiter side: drives completions and the memory bus.
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output if_ack, if_err, if_rdata, ls_ack, ls_err, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters and memory side.
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  if_ack, if_err, if_rdata, ls_ack, ls_err, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick; the 'last' history bit lives in the caller.
module arb_rr2
    import cpu_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = if_req | ls_req;
        if (if_req && ls_req) begin
            gnt_id = ~last;
        end else if (ls_req) begin
            gnt_id = GNT_LS;
        end else begin
            gnt_id = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port memory bus between instruction fetch and load/store,
// running one IDLE->BUSY->ACK transaction per grant with a bounded wait.
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.master   bus
);

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic              ls_ack_q, ls_ack_d, ls_err_q, ls_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic              busy_q, busy_d;

    logic              gnt_valid, gnt_id;
    logic              timed_out;
    logic [DATA_W-1:0] rd_val;

    arb_rr2 u_arb (
        .if_req    (bus.if_req),
        .ls_req    (bus.ls_req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        ls_ack_d    = 1'b0;
        ls_err_d    = 1'b0;
        timed_out   = ~bus.mem_ready;
        rd_val      = bus.mem_ready ? bus.mem_rdata : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d  = ST_BUSY;
                    grant_d  = gnt_id;
                    last_d   = gnt_id;
                    cnt_d    = '0;
                    mem_en_d = 1'b1;
                    if (gnt_id == GNT_LS) begin
                        mem_addr_d  = bus.ls_addr;
                        mem_we_d    = bus.ls_we;
                        mem_wdata_d = bus.ls_wdata;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                // Ready takes priority over the timeout when both land in the same cycle.
                if (bus.mem_ready || cnt_q == CNT_LAST) begin
                    state_d  = ST_ACK;
                    mem_en_d = 1'b0;
                    if (grant_q == GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = timed_out;
                        if_rdata_d = rd_val;
                    end else begin
                        ls_ack_d = 1'b1;
                        ls_err_d = timed_out;
                        if (!mem_we_q) begin
                            ls_rdata_d = rd_val;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_LS;
            grant_q     <= GNT_IF;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            ls_ack_q    <= ls_ack_d;
            ls_err_q    <= ls_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_ack    = ls_ack_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-timing reference model.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int          TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each grant becomes a window [beg, beg+dur) of bus activity
    // followed by one ack cycle; dur follows from the programmed memory latency.
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_beg = 0, m_dur = 0, m_lat = 0;
    bit         m_id = 1'b0, m_last = 1'b1, m_we = 1'b0, m_err = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0, m_exp = '0;
    logic [7:0] m_if_rd = '0, m_ls_rd = '0;
    int         lat_q[$];
    bit         gnt_log[$];
    logic [7:0] mem[256];
    bit         stray = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_if_rd  = '0;
            m_ls_rd  = '0;
        end else begin
            cyc++;
            if (!m_active) begin
                if (bus.if_req || bus.ls_req) begin
                    m_id    = (bus.if_req && bus.ls_req) ? !m_last : bus.ls_req;
                    m_last  = m_id;
                    gnt_log.push_back(m_id);
                    m_addr  = m_id ? bus.ls_addr : bus.if_addr;
                    m_we    = m_id && bus.ls_we;
                    m_wdata = bus.ls_wdata;
                    m_lat   = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                    m_err   = (m_lat >= TO);
                    m_dur   = m_err ? TO : m_lat + 1;
                    m_exp   = mem[m_addr];
                    m_beg   = cyc;
                    m_active = 1'b1;
                end
            end else if (cyc == m_beg + m_dur) begin
                if (!m_we) begin
                    if (m_id) m_ls_rd = m_err ? 8'h00 : m_exp;
                    else      m_if_rd = m_err ? 8'h00 : m_exp;
                end
            end else if (cyc == m_beg + m_dur + 1) begin
                m_active = 1'b0;
            end
        end
    end

    // Memory responder: ready after the programmed number of wait cycles.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && m_active && m_lat < TO && cyc == m_beg + m_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_ready = stray && rst && !(m_active && cyc >= m_beg && cyc < m_beg + m_dur);
                bus.mem_rdata = 8'hEE;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit in_b;
        bit in_a;
        if (rst) begin
            in_b = m_active && cyc >= m_beg && cyc < m_beg + m_dur;
            in_a = m_active && cyc == m_beg + m_dur;
            chk("mem_en", bus.mem_en, in_b);
            chk("busy", bus.busy, in_b || in_a);
            chk("if_ack", bus.if_ack, in_a && !m_id);
            chk("ls_ack", bus.ls_ack, in_a && m_id);
            chk("if_err", bus.if_err, in_a && !m_id && m_err);
            chk("ls_err", bus.ls_err, in_a && m_id && m_err);
            chk("if_rdata", bus.if_rdata, m_if_rd);
            chk("ls_rdata", bus.ls_rdata, m_ls_rd);
            if (in_b) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_we", bus.mem_we, m_we);
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (port ? bus.ls_ack : bus.if_ack) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_ack: got no ack on port %0d expected ack within 40 cycles", port);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int b, at1, at2, n0;
        int seq[$];
        bit exp_alt[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        #3;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_ls_ack", bus.ls_ack, 0);
        chk("rst_if_err", bus.if_err, 0);
        chk("rst_ls_err", bus.ls_err, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_ls_rdata", bus.ls_rdata, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single zero-wait fetch.
        mem[8'h10] = 8'hA5;
        lat_q.push_back(0);
        bus.if_addr = 8'h10; bus.if_req = 1'b1;
        tick();
        chk("s1_mem_en_c1", bus.mem_en, 1);
        chk("s1_busy_c1", bus.busy, 1);
        chk("s1_addr_c1", bus.mem_addr, 8'h10);
        tick();
        chk("s1_ack_c2", bus.if_ack, 1);
        chk("s1_rdata", bus.if_rdata, 8'hA5);
        chk("s1_err", bus.if_err, 0);
        chk("s1_busy_c2", bus.busy, 1);
        bus.if_req = 1'b0;
        tick();
        chk("s1_busy_c3", bus.busy, 0);

        // Store with three wait cycles.
        lat_q.push_back(3);
        bus.ls_we = 1'b1; bus.ls_addr = 8'h20; bus.ls_wdata = 8'h3C; bus.ls_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s2_mem_en", bus.mem_en, 1);
            chk("s2_mem_we", bus.mem_we, 1);
            chk("s2_addr", bus.mem_addr, 8'h20);
            chk("s2_wdata", bus.mem_wdata, 8'h3C);
            chk("s2_no_ack", bus.ls_ack, 0);
            tick();
        end
        chk("s2_ack_c5", bus.ls_ack, 1);
        chk("s2_err", bus.ls_err, 0);
        chk("s2_rdata_kept", bus.ls_rdata, 0);
        chk("s2_mem_written", mem[8'h20], 8'h3C);
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
        tick();

        // Both ports held for four transactions after reset.
        do_reset();
        mem[8'h30] = 8'h11; mem[8'h40] = 8'h22;
        lat_q = '{0, 1, 0, 2};
        gnt_log.delete();
        bus.if_addr = 8'h30; bus.ls_addr = 8'h40; bus.ls_we = 1'b0;
        bus.if_req = 1'b1; bus.ls_req = 1'b1;
        for (int i = 0; i < 40 && seq.size() < 4; i++) begin
            tick();
            if (bus.if_ack) seq.push_back(0);
            if (bus.ls_ack) seq.push_back(1);
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        chk("s3_ack_count", seq.size(), 4);
        chk("s3_model_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seq.size()) chk("s3_ack_order", seq[i], exp_alt[i]);
            if (i < gnt_log.size()) chk("s3_model_order", gnt_log[i], exp_alt[i]);
        end
        chk("s3_if_rdata", bus.if_rdata, 8'h11);
        chk("s3_ls_rdata", bus.ls_rdata, 8'h22);
        tick();

        // Timeout load, then ready in the last allowed BUSY cycle.
        stray = 1'b1;
        mem[8'h50] = 8'h77;
        lat_q.push_back(99);
        bus.ls_addr = 8'h50; bus.ls_req = 1'b1;
        b = cyc;
        wait_ack(1'b1, at1);
        chk("s4_timeout_cycle", at1 - b, 17);
        chk("s4_timeout_err", bus.ls_err, 1);
        chk("s4_timeout_rdata", bus.ls_rdata, 0);
        bus.ls_req = 1'b0;
        tick();
        lat_q.push_back(15);
        bus.ls_req = 1'b1;
        b = cyc;
        wait_ack(1'b1, at1);
        chk("s4_late_cycle", at1 - b, 17);
        chk("s4_late_err", bus.ls_err, 0);
        chk("s4_late_rdata", bus.ls_rdata, 8'h77);
        bus.ls_req = 1'b0;
        stray = 1'b0;
        tick();

        // Asynchronous reset in the second BUSY cycle.
        do_reset();
        lat_q = '{99, 0, 0};
        bus.if_addr = 8'h30; bus.ls_addr = 8'h40;
        bus.if_req = 1'b1; bus.ls_req = 1'b1;
        tick();
        tick();
        chk("s5_busy_before", bus.mem_en, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("s5_mem_en_async", bus.mem_en, 0);
        chk("s5_busy_async", bus.busy, 0);
        chk("s5_if_ack_async", bus.if_ack, 0);
        chk("s5_ls_ack_async", bus.ls_ack, 0);
        chk("s5_addr_async", bus.mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.if_ack || bus.ls_ack) break;
        end
        chk("s5_restart_if", bus.if_ack, 1);
        chk("s5_restart_not_ls", bus.ls_ack, 0);
        bus.if_req = 1'b0;
        wait_ack(1'b1, at1);
        bus.ls_req = 1'b0;
        tick();

        // Back-to-back fetches with request held high.
        mem[8'h60] = 8'hC1; mem[8'h61] = 8'hC2;
        lat_q = '{0, 0};
        n0 = gnt_log.size();
        bus.if_addr = 8'h60; bus.if_req = 1'b1;
        b = cyc;
        wait_ack(1'b0, at1);
        chk("s6_first_latency", at1 - b, 2);
        chk("s6_first_rdata", bus.if_rdata, 8'hC1);
        bus.if_addr = 8'h61;
        wait_ack(1'b0, at2);
        chk("s6_ack_spacing", at2 - at1, 3);
        chk("s6_second_rdata", bus.if_rdata, 8'hC2);
        bus.if_req = 1'b0;
        tick();
        tick();
        chk("s6_two_grants", gnt_log.size() - n0, 2);
        chk("s6_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
